// File: rtl/clkword_edgecount_pkg.sv
// rtl/clkword_edgecount_pkg.sv - shared widths and state encoding for the clock-word edge counter
// Purpose: default widths (edge accumulator, gate length, clock word) and FSM state type.
// Ports: none (package).
package clkword_edgecount_pkg;

    localparam int CW_DEF = 32;
    localparam int GW_DEF = 16;
    localparam int WORD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/clkword_edgevec.sv
// rtl/clkword_edgevec.sv - rising-edge detect and popcount for one oversampled clock word
// Purpose: counts 0..4 rising edges in an 8-bit word, bit 7 earliest in time.
// Ports:
//   word_i  - clock word, bit 7 first in time
//   prev_i  - last bit (bit 0) of the previous accepted word
//   count_o - number of rising edges in this word (combinational)
module clkword_edgevec
    import clkword_edgecount_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic              prev_i,
    output logic [2:0]        count_o
);

    logic [WORD_W-1:0] edges;

    // Each bit's temporal predecessor sits one position higher; bit 7 looks back to prev_i.
    assign edges = word_i & ~{prev_i, word_i[WORD_W-1:1]};

    always_comb begin
        count_o = 3'd0;
        for (int i = 0; i < WORD_W; i++) begin
            count_o = count_o + {2'b00, edges[i]};
        end
    end

endmodule

// File: rtl/clkword_edgecount.sv
// rtl/clkword_edgecount.sv - gated rising-edge counter over a stream of oversampled clock words
// Purpose: counts rising edges over i_gate_len accepted words after i_start, saturating result.
// Ports:
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_word, i_ce            - clock word (bit 7 first) and its valid strobe
//   i_start, i_gate_len     - window request and its length in words (0 behaves as 1)
//   o_busy                  - window running or result still in the pipeline
//   o_valid, o_count, o_ovf - result pulse, edge count, saturation flag (held until next result)
module clkword_edgecount
    import clkword_edgecount_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int GW = GW_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_ce,
    input  logic              i_start,
    input  logic [GW-1:0]     i_gate_len,
    output logic              o_busy,
    output logic              o_valid,
    output logic [CW-1:0]     o_count,
    output logic              o_ovf
);

    state_e          state_q, state_d;
    logic            hist_q, hist_d;
    logic [GW-1:0]   wcnt_q, wcnt_d;
    logic [2:0]      cnt1_q, cnt1_d;
    logic            v1_q, v1_d;
    logic            last1_q, last1_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_out_q, ovf_out_d;

    logic [2:0]      edge_cnt;
    logic [CW:0]     sum;
    logic            clip;
    logic [CW-1:0]   acc_sat;

    clkword_edgevec u_edgevec (
        .word_i  (i_word),
        .prev_i  (hist_q),
        .count_o (edge_cnt)
    );

    // Stage-2 add is one bit wider so a carry out flags saturation.
    assign sum     = {1'b0, acc_q} + {{(CW - 2){1'b0}}, cnt1_q};
    assign clip    = sum[CW];
    assign acc_sat = clip ? {CW{1'b1}} : sum[CW-1:0];

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        wcnt_d    = wcnt_q;
        cnt1_d    = cnt1_q;
        v1_d      = 1'b0;
        last1_d   = 1'b0;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        count_d   = count_q;
        ovf_out_d = ovf_out_q;

        // History follows every accepted word, so edges spanning window boundaries are seen once.
        if (i_ce) begin
            hist_d = i_word[0];
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    wcnt_d  = (i_gate_len == '0) ? GW'(1) : i_gate_len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_ce) begin
                    v1_d    = 1'b1;
                    cnt1_d  = edge_cnt;
                    last1_d = (wcnt_q == GW'(1));
                    wcnt_d  = wcnt_q - GW'(1);
                    if (wcnt_q == GW'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: ;
            default: state_d = ST_IDLE;
        endcase

        // Stage 2: the final word's result goes straight to the output registers.
        if (v1_q) begin
            acc_d = acc_sat;
            ovf_d = ovf_q | clip;
            if (last1_q) begin
                valid_d   = 1'b1;
                count_d   = acc_sat;
                ovf_out_d = ovf_q | clip;
                state_d   = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            hist_q    <= 1'b0;
            wcnt_q    <= '0;
            cnt1_q    <= '0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            wcnt_q    <= wcnt_d;
            cnt1_q    <= cnt1_d;
            v1_q      <= v1_d;
            last1_q   <= last1_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign o_busy  = (state_q != ST_IDLE);
    assign o_valid = valid_q;
    assign o_count = count_q;
    assign o_ovf   = ovf_out_q;

endmodule

// File: tb/tb_clkword_edgecount.sv
// tb/tb_clkword_edgecount.sv - randomized self-checking bench for clkword_edgecount
module tb_clkword_edgecount;

    localparam int GW = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_word;
    logic        i_ce;
    logic        i_start;
    logic [GW-1:0] i_gate_len;

    logic        busy32, valid32, ovf32;
    logic [31:0] count32;
    logic        busy4, valid4, ovf4;
    logic [3:0]  count4;

    int checks = 0;
    int failures = 0;
    int vcount32 = 0;
    int vcount4 = 0;
    logic model_prev = 1'b0;

    clkword_edgecount #(.CW(32), .GW(GW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_word(i_word), .i_ce(i_ce),
        .i_start(i_start), .i_gate_len(i_gate_len),
        .o_busy(busy32), .o_valid(valid32), .o_count(count32), .o_ovf(ovf32)
    );

    clkword_edgecount #(.CW(4), .GW(GW)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_word(i_word), .i_ce(i_ce),
        .i_start(i_start), .i_gate_len(i_gate_len),
        .o_busy(busy4), .o_valid(valid4), .o_count(count4), .o_ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid32) vcount32++;
        if (valid4)  vcount4++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Walks the bit stream in time order: rising edge = 1 after a 0.
    function automatic int edges_of(input logic [7:0] w, input logic p);
        int n = 0;
        logic b = p;
        for (int i = 7; i >= 0; i--) begin
            if (w[i] && !b) n++;
            b = w[i];
        end
        return n;
    endfunction

    function automatic logic pick_ce(input int mode, input int k);
        if (mode == 1) return logic'($urandom_range(0, 1));
        if (mode == 2) return (k == 0) || (k % 2 == 1);
        return 1'b1;
    endfunction

    task automatic drive(input logic st, input logic ce, input logic [7:0] w, input int gl);
        @(posedge clk);
        #1;
        i_start    = st;
        i_ce       = ce;
        i_word     = w;
        i_gate_len = gl[GW-1:0];
        if (ce && rst_n) model_prev = w[0];
    endtask

    task automatic idle_cycles(input int n, input bit rnd, input logic [7:0] wc);
        logic [7:0] w;
        logic ce;
        for (int i = 0; i < n; i++) begin
            w  = rnd ? 8'($urandom) : wc;
            ce = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
            drive(1'b0, ce, w, 0);
        end
    endtask

    task automatic window(input string tag, input int gate, input int ce_mode,
                          input logic [7:0] wc, input bit rnd_word, input bit dbl_start);
        int g, counted, total, k, v32_0, v4_0, exp4;
        logic ce;
        logic [7:0] w;
        g = (gate == 0) ? 1 : gate;
        v32_0 = vcount32;
        v4_0  = vcount4;
        ce = pick_ce(ce_mode, 0);
        w  = rnd_word ? 8'($urandom) : wc;
        drive(1'b1, ce, w, gate);
        counted = 0;
        total   = 0;
        k       = 0;
        while (counted < g && k < 400) begin
            k++;
            ce = pick_ce(ce_mode, k);
            w  = rnd_word ? 8'($urandom) : wc;
            if (ce) total += edges_of(w, model_prev);
            if (ce) counted++;
            drive(dbl_start && k == 1, ce, w, $urandom_range(0, 3));
            @(negedge clk);
            check({tag, " busy_run"}, busy32, 1);
            check({tag, " novalid_run"}, valid32, 0);
        end
        if (counted < g) check({tag, " window_timeout"}, counted, g);
        w = rnd_word ? 8'($urandom) : wc;
        drive(1'b0, pick_ce(ce_mode, k + 1), w, 0);
        @(negedge clk);
        check({tag, " valid_early"}, valid32, 0);
        check({tag, " busy_flush"}, busy32, 1);
        w = rnd_word ? 8'($urandom) : wc;
        drive(1'b0, pick_ce(ce_mode, k + 2), w, 0);
        @(negedge clk);
        exp4 = (total > 15) ? 15 : total;
        check({tag, " valid"}, valid32, 1);
        check({tag, " busy_done"}, busy32, 0);
        check({tag, " count32"}, count32, total);
        check({tag, " ovf32"}, ovf32, 0);
        check({tag, " valid4"}, valid4, 1);
        check({tag, " count4"}, count4, exp4);
        check({tag, " ovf4"}, ovf4, total > 15);
        drive(1'b0, 1'b1, wc, 0);
        @(negedge clk);
        check({tag, " valid_pulse"}, valid32, 0);
        check({tag, " count_held"}, count32, total);
        check({tag, " one_pulse32"}, vcount32 - v32_0, 1);
        check({tag, " one_pulse4"}, vcount4 - v4_0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_ce = 1'b0;
        model_prev = 1'b0;
        #1;
        check("rst_busy", busy32, 0);
        check("rst_valid", valid32, 0);
        check("rst_count", count32, 0);
        check("rst_ovf", ovf32, 0);
        check("rst_count4", count4, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int v0, gate;
        rst_n = 1'b0;
        i_word = 8'h00;
        i_ce = 1'b0;
        i_start = 1'b0;
        i_gate_len = '0;
        #2;
        check("init_busy", busy32, 0);
        check("init_valid", valid32, 0);
        check("init_count", count32, 0);
        check("init_ovf", ovf4, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Constant-word directed windows.
        window("aa_g4", 4, 0, 8'hAA, 0, 0);
        idle_cycles(2, 0, 8'h0F);
        window("0f_g10", 10, 0, 8'h0F, 0, 0);

        do_reset();
        idle_cycles(2, 0, 8'hFF);
        window("ff_g5", 5, 0, 8'hFF, 0, 0);

        do_reset();
        window("aa_sat", 4, 0, 8'hAA, 0, 0);
        window("aa_g1", 1, 0, 8'hAA, 0, 0);
        window("aa_ce_alt", 3, 2, 8'hAA, 0, 1);
        window("aa_g0", 0, 0, 8'hAA, 0, 0);

        // Reset mid-window aborts with no result.
        drive(1'b1, 1'b1, 8'hAA, 8);
        repeat (3) drive(1'b0, 1'b1, 8'hAA, 0);
        v0 = vcount32;
        do_reset();
        idle_cycles(12, 0, 8'hAA);
        @(negedge clk);
        check("abort_novalid", vcount32 - v0, 0);
        check("abort_busy", busy32, 0);
        check("abort_count", count32, 0);

        // Random windows: random words, random strobes, random gates, stray starts.
        for (int n = 0; n < 25; n++) begin
            gate = $urandom_range(0, 12);
            idle_cycles($urandom_range(0, 3), 1, 8'h00);
            window("rnd", gate, 1, 8'h00, 1, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clkword_edgecount.md
CLKWORD_EDGECOUNT -- requirements
Module: clkword_edgecount

Interface
REQ-001 SHALL have parameter CW, default 32, meaning width of edge-count accumulator and result.
REQ-002 SHALL have parameter GW, default 16, meaning width of gate-length (window size in words).
REQ-003 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_word  input  8  oversampled clock word, bit 7 first in time, bit 0 last.
REQ-006 SHALL have port i_ce  input  1  i_word valid this cycle; tied high when fed directly by the clock-word generator.
REQ-007 SHALL have port i_start  input  1  single-cycle request to begin a measurement window.
REQ-008 SHALL have port i_gate_len  input  GW  words per window, sampled on accepted i_start.
REQ-009 SHALL have port o_busy  output  1  window in progress or result pending.
REQ-010 SHALL have port o_valid  output  1  one-cycle pulse, o_count holds a new result.
REQ-011 SHALL have port o_count  output  CW  rising-edge count of last completed window.
REQ-012 SHALL have port o_ovf  output  1  last result saturated; valid with o_valid, held with o_count.

Function
REQ-013 SHALL define a rising edge as a bit equal to 1 whose temporally preceding bit equals 0; the predecessor of bit 7 is bit 0 of the previous accepted word.
REQ-014 SHALL keep a history bit, updated with i_word[0] on every i_ce cycle regardless of state, so window boundaries never lose or double-count an edge.
REQ-015 SHALL count 0..4 edges per word (8-bit edge vector, popcount).
REQ-016 SHALL implement states IDLE, RUN, FLUSH, with o_busy=1 in RUN and FLUSH.
REQ-017 IDLE -> RUN on i_start: load word counter from i_gate_len (0 treated as 1), clear accumulator and overflow flag.
REQ-018 i_start while RUN or FLUSH SHALL be ignored.
REQ-019 In RUN each i_ce cycle SHALL count one word; the word arriving on the i_start cycle is not counted; first counted word is the next i_ce word.
REQ-020 RUN -> FLUSH after the i_gate_len-th counted word; FLUSH -> IDLE when the pipeline drains.
REQ-021 SHALL pipeline as stage 1 registered edge vector, stage 2 accumulate; o_valid SHALL pulse exactly 2 cycles after the cycle of the final counted word, on the same edge as FLUSH -> IDLE.
REQ-022 Accumulator SHALL saturate at 2^CW-1; any clipped addition sets o_ovf for that result.
REQ-023 o_count and o_ovf SHALL update only with o_valid and hold until the next result.
REQ-024 i_ce low in RUN SHALL stall the window counter and add nothing; no timeout.

Reset
REQ-025 On i_rst_n low, immediately: state IDLE, history bit 0, o_busy 0, o_valid 0, o_count 0, o_ovf 0, counters and pipeline cleared.
REQ-026 Reset mid-window SHALL abort with no o_valid; a new i_start is required after release.

Structure
REQ-027 State encoding typedef and default widths (CW, GW, word width 8) SHALL live in the shared clock-generation package.
REQ-028 Edge detect plus popcount SHALL be one sub-module, clkword_edgevec (inputs word and previous bit, output 3-bit count), combinational, registered in the parent.

Verification
REQ-029 After reset, i_ce=1, i_word=8'hAA constant, i_start with gate 4 -> o_valid once, o_count=16, o_ovf=0, 6 cycles after i_start.
REQ-030 i_word=8'h0F constant, gate 10 -> o_count=10; i_word=8'hFF constant from reset, start on the 3rd cycle, gate 5 -> o_count=0 (the sole edge precedes the window).
REQ-031 CW=4, i_word=8'hAA, gate 4 -> o_count=15, o_ovf=1; next window with gate 1 -> o_count=4, o_ovf=0.
REQ-032 Gate 3 with i_ce toggling 1,0,1,0,1 on 8'hAA -> o_count=12, o_valid 2 cycles after the 3rd i_ce word; second i_start during RUN ignored.
REQ-033 Assert i_rst_n low mid-window at gate 8 -> no o_valid, outputs zero; i_gate_len=0 start -> o_count from exactly one word.
